if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS32 pipeline.
- Owns the PC register and drives the word address into the combinational instruction ROM. Takes the returned instruction into the IF/ID pipeline register.
- Resolves the next PC: sequential, J/JAL (decoded locally from IF/ID), JR/JALR (from ID), taken branch (from EX) and exception vector.
- Handles load-use stall and control-hazard flush for the front end.

Parameters:
- RESET_PC, 32'h0040_0000, PC value after reset; first fetch address.
- EXC_VECTOR, 32'h8000_0008, PC loaded on exc_req.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID (load-use).
- branch_taken  in  1  EX stage: branch resolved taken this cycle.
- branch_target  in  32  EX stage branch target.
- jr_req  in  1  ID stage: JR/JALR in ID, operand available.
- jr_target  in  32  forwarded rs value for JR/JALR.
- exc_req  in  1  exception/interrupt redirect request.
- inst_addr  out  32  current PC, to instruction memory Addr.
- inst_rdata  in  32  instruction returned combinationally for inst_addr.
- if_id_inst  out  32  registered instruction to ID.
- if_id_pc_plus4  out  32  registered PC+4 of if_id_inst.
- if_id_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- fetch_count  out  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset (async, while reset=1): pc=RESET_PC, if_id_inst=NOP_INST, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0. Outputs are valid the same cycle reset asserts. Reset mid-operation discards any pending redirect.
- inst_addr = pc, driven combinationally. Fetch latency is 0 cycles: inst_rdata is captured at the next rising edge.
- Local jump detect: jump_id = if_id_valid & (if_id_inst[31:26]==6'h02 or 6'h03). The jump target is {if_id_pc_plus4[31:28], if_id_inst[25:0], 2'b00}.
- Next-PC priority, highest first, evaluated each rising edge:
  1. exc_req: pc<=EXC_VECTOR; flush IF/ID.
  2. branch_taken: pc<=branch_target; flush IF/ID. This overrides stall, because the instruction in ID is on the wrong path.
  3. stall: pc and IF/ID hold; jump_id and jr_req are ignored this cycle.
  4. jr_req: pc<=jr_target; flush IF/ID.
  5. jump_id: pc<=jump target; flush IF/ID.
  6. default: pc<=pc+4; IF/ID<={inst_rdata, pc+4, valid=1}; fetch_count+=1.
- Flush: if_id_inst<=NOP_INST, if_id_valid<=0, if_id_pc_plus4<=0. fetch_count does not increment.
- jr_req and jump_id together cannot occur legally. If they do, jr_req wins.
- pc+4 uses 32-bit wrap-around: 32'hFFFF_FFFC goes to 32'h0000_0000. No alignment check is made; pc[1:0] of a redirect target is passed through as given.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- Only the sequential path captures from inst_rdata, so the redirect penalty is a 1-cycle bubble for J/JR and a 2-cycle bubble for a taken branch. The EX→ID/EX flush is outside this block.

Test Plan:
- Reset release, inst_rdata=32'h24100000 at 0x00400000: first edge gives if_id_inst=32'h24100000, if_id_pc_plus4=0x00400004, if_id_valid=1, inst_addr=0x00400004, fetch_count=1.
- Jump: IF/ID holds 32'h08100054 with pc_plus4=0x00400020 → next edge inst_addr=0x00400150, if_id_valid=0, and the following edge fetches from 0x00400150.
- stall=1 for 3 cycles mid-stream: inst_addr, if_id_* and fetch_count stay constant; after release, sequential fetch resumes at the held PC with no lost or duplicated instruction.
- branch_taken=1, target 0x00400040, together with stall=1 and jump_id active: pc=0x00400040 and IF/ID is flushed. exc_req added in the same cycle instead gives pc=0x80000008.
- jr_req=1 with jr_target=0x00400018: pc=0x00400018 and the bubble is inserted. With stall=1 as well, jr_req is ignored and pc holds.
- Assert reset asynchronously between edges after a redirect: outputs return to reset values immediately, and the first fetch after release is RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the 5-stage MIPS32 pipeline.
//
// Owns the PC, presents it to a combinational instruction ROM and captures
// the returned word into the IF/ID register. Picks the next PC from, in
// priority order: exception vector, taken branch (EX), stall hold,
// JR/JALR target (ID), local J/JAL decode of IF/ID, and sequential PC+4.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   stall          hold PC and IF/ID (load-use)
//   branch_taken   EX branch resolved taken; branch_target is the new PC
//   jr_req         JR/JALR in ID; jr_target is the forwarded rs value
//   exc_req        exception/interrupt redirect to EXC_VECTOR
//   inst_addr      current PC to instruction memory
//   inst_rdata     instruction returned combinationally for inst_addr
//   if_id_inst     registered instruction to ID
//   if_id_pc_plus4 registered PC+4 of if_id_inst
//   if_id_valid    1 = real instruction, 0 = bubble
//   fetch_count    instructions accepted into IF/ID since reset (wraps)
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;
  logic [31:0] count_reg, count_next;

  logic [31:0] pc_plus4;
  logic [5:0]  id_opcode;
  logic        jump_id;
  logic [31:0] jump_target;

  // 32-bit wrap-around is intended: 0xFFFF_FFFC + 4 gives 0.
  assign pc_plus4  = pc_reg + 32'd4;
  assign id_opcode = inst_reg[31:26];

  // J (0x02) / JAL (0x03) are resolved from IF/ID so they cost one bubble
  // instead of waiting for the decoder.
  assign jump_id     = valid_reg && ((id_opcode == 6'h02) || (id_opcode == 6'h03));
  assign jump_target = {pc4_reg[31:28], inst_reg[25:0], 2'b00};

  always_comb begin
    // Default: hold everything (also the stall behaviour).
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    pc4_next   = pc4_reg;
    valid_next = valid_reg;
    count_next = count_reg;

    if (exc_req || branch_taken || (!stall && (jr_req || jump_id))) begin
      // Any redirect flushes IF/ID: what it holds is on the wrong path.
      inst_next  = NOP_INST;
      pc4_next   = 32'd0;
      valid_next = 1'b0;
      if (exc_req)           pc_next = EXC_VECTOR;
      else if (branch_taken) pc_next = branch_target;  // beats stall
      else if (jr_req)       pc_next = jr_target;      // beats jump_id
      else                   pc_next = jump_target;
    end else if (!stall) begin
      // Only the sequential path captures from the ROM.
      pc_next    = pc_plus4;
      inst_next  = inst_rdata;
      pc4_next   = pc_plus4;
      valid_next = 1'b1;
      count_next = count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      inst_reg  <= NOP_INST;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
      count_reg <= 32'd0;
    end else begin
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      pc4_reg   <= pc4_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  assign inst_addr      = pc_reg;
  assign if_id_inst     = inst_reg;
  assign if_id_pc_plus4 = pc4_reg;
  assign if_id_valid    = valid_reg;
  assign fetch_count    = count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with hand-computed expected values.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jr_req;
  logic [31:0] jr_target;
  logic        exc_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int chk_cnt;
  int pass_cnt;
  int cyc;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jr_req         (jr_req),
    .jr_target      (jr_target),
    .exc_req        (exc_req),
    .inst_addr      (inst_addr),
    .inst_rdata     (inst_rdata),
    .if_id_inst     (if_id_inst),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM: addiu-style words tagged with the low address bits,
  // plus the reset-vector word and two J instructions (target 0x00400150).
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0040_0000)      return 32'h2410_0000;
    else if (a == 32'h0040_001C) return 32'h0810_0054;
    else if (a == 32'h0040_0158) return 32'h0810_0054;
    else                         return {16'h2400, a[15:0]};
  endfunction

  assign inst_rdata = rom(inst_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d: pc=%08h inst=%08h pc4=%08h v=%0d cnt=%0d",
             cyc, inst_addr, if_id_inst, if_id_pc_plus4, if_id_valid, fetch_count);
  endtask

  task automatic clear_ctl();
    stall = 0; branch_taken = 0; jr_req = 0; exc_req = 0;
    branch_target = 32'h0; jr_target = 32'h0;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; cyc = 0;
    reset = 1'b1;
    clear_ctl();

    // Reset state
    #2;
    check_eq("rst_addr",  inst_addr, 32'h0040_0000);
    check_eq("rst_inst",  if_id_inst, 32'h0);
    check_eq("rst_pc4",   if_id_pc_plus4, 32'h0);
    check_eq("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check_eq("rst_count", fetch_count, 32'h0);
    #1 reset = 1'b0;

    // First fetch
    tick();
    check_eq("f1_inst",  if_id_inst, 32'h2410_0000);
    check_eq("f1_pc4",   if_id_pc_plus4, 32'h0040_0004);
    check_eq("f1_valid", {31'b0, if_id_valid}, 32'h1);
    check_eq("f1_addr",  inst_addr, 32'h0040_0004);
    check_eq("f1_count", fetch_count, 32'h1);

    // Run sequentially until the J at 0x0040001C lands in IF/ID
    for (int i = 0; i < 6; i++) tick();
    check_eq("seq_addr", inst_addr, 32'h0040_001C);
    tick();
    check_eq("j_inst",  if_id_inst, 32'h0810_0054);
    check_eq("j_pc4",   if_id_pc_plus4, 32'h0040_0020);
    check_eq("j_count", fetch_count, 32'h8);

    // Jump resolves: one bubble
    tick();
    check_eq("jmp_addr",  inst_addr, 32'h0040_0150);
    check_eq("jmp_valid", {31'b0, if_id_valid}, 32'h0);
    check_eq("jmp_count", fetch_count, 32'h8);
    tick();
    check_eq("jmp_fetch_pc4",  if_id_pc_plus4, 32'h0040_0154);
    check_eq("jmp_fetch_inst", if_id_inst, 32'h2400_0150);
    check_eq("jmp_fetch_cnt",  fetch_count, 32'h9);

    // Three stall cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_addr",  inst_addr, 32'h0040_0154);
      check_eq("stall_inst",  if_id_inst, 32'h2400_0150);
      check_eq("stall_count", fetch_count, 32'h9);
    end
    stall = 1'b0;
    tick();
    check_eq("unstall_inst",  if_id_inst, 32'h2400_0154);
    check_eq("unstall_pc4",   if_id_pc_plus4, 32'h0040_0158);
    check_eq("unstall_count", fetch_count, 32'hA);

    // Bring the J at 0x00400158 into IF/ID, then branch+stall+jump together
    tick();
    check_eq("j2_inst", if_id_inst, 32'h0810_0054);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0040_0040;
    tick();
    check_eq("br_addr",  inst_addr, 32'h0040_0040);
    check_eq("br_valid", {31'b0, if_id_valid}, 32'h0);
    check_eq("br_inst",  if_id_inst, 32'h0);
    check_eq("br_pc4",   if_id_pc_plus4, 32'h0);
    check_eq("br_count", fetch_count, 32'hB);

    // Exception beats branch and stall
    exc_req = 1'b1;
    tick();
    check_eq("exc_addr",  inst_addr, 32'h8000_0008);
    check_eq("exc_count", fetch_count, 32'hB);
    clear_ctl();
    tick();
    check_eq("exc_fetch", if_id_inst, 32'h2400_0008);
    check_eq("exc_count2", fetch_count, 32'hC);

    // JR redirect
    jr_req = 1'b1; jr_target = 32'h0040_0018;
    tick();
    check_eq("jr_addr",  inst_addr, 32'h0040_0018);
    check_eq("jr_valid", {31'b0, if_id_valid}, 32'h0);
    check_eq("jr_count", fetch_count, 32'hC);
    clear_ctl();
    tick();
    check_eq("jr_fetch", if_id_inst, 32'h2400_0018);

    // JR ignored under stall
    jr_req = 1'b1; jr_target = 32'h0040_0100; stall = 1'b1;
    tick();
    check_eq("jrst_addr",  inst_addr, 32'h0040_001C);
    check_eq("jrst_valid", {31'b0, if_id_valid}, 32'h1);
    check_eq("jrst_count", fetch_count, 32'hD);

    // PC wrap-around
    clear_ctl();
    jr_req = 1'b1; jr_target = 32'hFFFF_FFFC;
    tick();
    check_eq("wrap_addr0", inst_addr, 32'hFFFF_FFFC);
    clear_ctl();
    tick();
    check_eq("wrap_addr", inst_addr, 32'h0);
    check_eq("wrap_pc4",  if_id_pc_plus4, 32'h0);
    check_eq("wrap_inst", if_id_inst, 32'h2400_FFFC);
    check_eq("wrap_count", fetch_count, 32'hE);

    // Async reset between edges after a redirect
    jr_req = 1'b1; jr_target = 32'h0040_0080;
    tick();
    clear_ctl();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_addr",  inst_addr, 32'h0040_0000);
    check_eq("arst_valid", {31'b0, if_id_valid}, 32'h0);
    check_eq("arst_count", fetch_count, 32'h0);
    check_eq("arst_inst",  if_id_inst, 32'h0);
    #2 reset = 1'b0;
    tick();
    check_eq("rel_inst",  if_id_inst, 32'h2410_0000);
    check_eq("rel_pc4",   if_id_pc_plus4, 32'h0040_0004);
    check_eq("rel_count", fetch_count, 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
